// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package inst_mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA,
        FLUSH,
        DONE
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid fires
// combinationally alongside the 4th byte so the holding register frees at once.
module byte_packer
    import inst_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt;
    logic [23:0] hold;

    assign word_valid = byte_en && (cnt == 2'(BYTES_PER_WORD - 1));
    assign word       = {byte_in, hold};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            hold <= '0;
        end else if (clr) begin
            cnt  <= '0;
            hold <= '0;
        end else if (byte_en) begin
            cnt <= cnt + 2'd1;
            case (cnt)
                2'd0:    hold[7:0]   <= byte_in;
                2'd1:    hold[15:8]  <= byte_in;
                2'd2:    hold[23:16] <= byte_in;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Streams a length-prefixed image into the instruction memory write port and
// holds the core in reset until the image is complete.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_wr,
    output logic             cpu_rst,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [15:0]      words_loaded
);

    localparam logic [16:0] CAP = 17'd1 << DEPTH;

    state_t      state, nxt;
    logic        accept, start_ok;
    logic [7:0]  hdr_lo;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [31:0] word;
    logic        word_valid;

    assign accept   = in_valid && in_ready;
    // load_start only counts where a load may begin; mid-load pulses must not clear the packer
    assign start_ok = load_start && (state == IDLE || state == DONE);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok),
        .byte_en    (accept && state == DATA),
        .byte_in    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:   if (load_start) nxt = HDR_LO;
            HDR_LO: if (accept) nxt = HDR_HI;
            HDR_HI: if (accept) nxt = ({in_data, hdr_lo} != 16'd0) ? DATA : FLUSH;
            DATA:   if (word_valid && (word_idx + 16'd1 == n_words)) nxt = FLUSH;
            FLUSH:  nxt = DONE;
            DONE:   if (load_start) nxt = HDR_LO;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == HDR_LO) || (state == HDR_HI) || (state == DATA);
        busy     = in_ready || (state == FLUSH);
        done     = (state == DONE);
        cpu_rst  = (state != DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_lo       <= '0;
            n_words      <= '0;
            word_idx     <= '0;
            mem_data     <= '0;
            mem_addr     <= '0;
            mem_wr       <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_wr <= 1'b0;
            if (start_ok) begin
                word_idx     <= '0;
                error        <= 1'b0;
                words_loaded <= '0;
            end
            if (accept && state == HDR_LO) hdr_lo <= in_data;
            if (accept && state == HDR_HI) begin
                n_words <= {in_data, hdr_lo};
                error   <= ({1'b0, in_data, hdr_lo} > CAP);
            end
            // Words past capacity are still counted so the load ends after N words
            if (word_valid) begin
                word_idx <= word_idx + 16'd1;
                if ({1'b0, word_idx} < CAP) begin
                    mem_wr       <= 1'b1;
                    mem_data     <= WIDTH'(word);
                    mem_addr     <= WIDTH'({word_idx, 2'b00});
                    words_loaded <= words_loaded + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboarded bench for inst_mem_loader with a 4-word memory.
module tb_inst_mem_loader;

    localparam int DEPTH_TB = 2;
    localparam int CAP      = 1 << DEPTH_TB;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk, rst, load_start, in_valid, in_ready;
    logic [7:0]  in_data;
    logic [31:0] mem_data, mem_addr;
    logic        mem_wr, cpu_rst, busy, done, error;
    logic [15:0] words_loaded;

    int          n_chk, n_fail, cyc;
    wr_t         sb_q[$];
    logic [31:0] img[$];

    inst_mem_loader #(.WIDTH(32), .DEPTH(DEPTH_TB)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_data     (mem_data),
        .mem_addr     (mem_addr),
        .mem_wr       (mem_wr),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && mem_wr) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_wr", mem_addr, 32'hffff_ffff);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_data, e.data);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int bound;
        bound    = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && bound < 20) begin
            @(posedge clk); #1;
            bound++;
        end
        if (bound >= 20) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic gap(input logic poke);
        in_valid   = 1'b0;
        load_start = poke;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    // stop_after < 0 streams the whole image; exp_cyc = 0 skips the timing check
    task automatic load(input logic [15:0] n, input bit toggle, input int stop_after,
                        input int exp_cyc);
        int  t0, sent, exp_wl;
        wr_t e;
        bit  stopped;
        stopped = 0;
        sent    = 0;
        exp_wl  = (int'(n) > CAP) ? CAP : int'(n);
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        t0 = cyc;
        @(negedge clk);
        chk("start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("start_wl", {16'd0, words_loaded}, 32'd0);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_err", {31'd0, error}, 32'd0);
        send(n[7:0]);
        if (toggle) gap(1'b0);
        send(n[15:8]);
        if (int'(n) > CAP) begin
            @(negedge clk);
            chk("hdr_err", {31'd0, error}, 32'd1);
        end
        for (int w = 0; w < int'(n) && !stopped; w++) begin
            for (int b = 0; b < 4 && !stopped; b++) begin
                if (stop_after >= 0 && sent == stop_after) begin
                    stopped = 1;
                end else begin
                    if (toggle) gap(w == 1 && b == 0);
                    if (b == 3 && w < CAP) begin
                        e.addr = 32'(w * 4);
                        e.data = img[w];
                        sb_q.push_back(e);
                    end
                    send(8'(img[w] >> (8 * b)));
                    sent++;
                end
            end
        end
        if (!stopped) begin
            if (exp_cyc != 0) chk("load_cycles", 32'(cyc - t0), 32'(exp_cyc));
            @(negedge clk);
            chk("rel_k1_cpu_rst", {31'd0, cpu_rst}, 32'd1);
            chk("rel_k1_done", {31'd0, done}, 32'd0);
            @(negedge clk);
            chk("rel_k2_cpu_rst", {31'd0, cpu_rst}, 32'd0);
            chk("rel_k2_done", {31'd0, done}, 32'd1);
            chk("rel_busy", {31'd0, busy}, 32'd0);
            chk("rel_wl", {16'd0, words_loaded}, 32'(exp_wl));
            chk("rel_err", {31'd0, error}, {31'd0, int'(n) > CAP});
            chk("sb_empty", 32'(sb_q.size()), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
        chk({pfx, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({pfx, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        chk({pfx, "_mem_data"}, mem_data, 32'd0);
        chk({pfx, "_mem_addr"}, mem_addr, 32'd0);
        chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
        chk({pfx, "_done"}, {31'd0, done}, 32'd0);
        chk({pfx, "_error"}, {31'd0, error}, 32'd0);
        chk({pfx, "_wl"}, {16'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // basic two-word image at one byte per cycle
        img = {32'h0000_0013, 32'h0010_0093};
        load(16'd2, 1'b0, -1, 10);

        // same image with in_valid toggling and a stray load_start mid-DATA
        load(16'd2, 1'b1, -1, 19);

        // empty image
        img = {};
        load(16'd0, 1'b0, -1, 2);

        // header larger than capacity: 5 words into a 4-word memory
        img = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
        load(16'd5, 1'b0, -1, 22);

        // abort with reset after 6 data bytes
        img = {32'hdead_beef, 32'hcafe_f00d};
        load(16'd2, 1'b0, 6, 0);
        rst = 1'b1;
        #1;
        chk_reset_vals("abort");
        #2;
        rst = 1'b0;
        @(posedge clk); #1;

        // fresh single-word image after the abort
        img = {32'hddcc_bbaa};
        load(16'd1, 1'b0, -1, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
